// File: rtl/uart_receiver_if.sv
// Pad-side line, line-control configuration and receive results of the UART receiver.
interface uart_receiver_if;
  logic [7:0] DLL;
  logic [7:0] DLH;
  logic       BGE;
  logic       OSM_SEL;
  logic       PEN;
  logic       STB;
  logic [1:0] WLS;
  logic       UART_RX_I;
  logic       baud_clk;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output DLL, DLH, BGE, OSM_SEL, PEN, STB, WLS, UART_RX_I,
    input  baud_clk, rx_done, rx_data, parity_err, frame_err
  );

  modport slave (
    input  DLL, DLH, BGE, OSM_SEL, PEN, STB, WLS, UART_RX_I,
    output baud_clk, rx_done, rx_data, parity_err, frame_err
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: programmable baud-tick generator, RX synchronizer and an
// oversampling deframer for start, 5-8 data, optional even parity and 1-2 stop bits.
module uart_receiver #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  uart_receiver_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  // Baud generator
  logic [15:0] divisor;
  logic [15:0] baud_cnt_q;
  logic        baud_q;
  logic        baud_en;
  logic        tick;

  assign divisor = {bus.DLH, bus.DLL};
  assign baud_en = bus.BGE && (divisor != 16'd0);
  // Gated by BGE so dropping the enable silences the tick in the same cycle.
  assign tick    = baud_q && bus.BGE;

  // Down-counter reloaded with divisor-1; registered one-clk tick on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_q <= '0;
      baud_q     <= 1'b0;
    end else if (!baud_en) begin
      baud_cnt_q <= divisor - 16'd1;
      baud_q     <= 1'b0;
    end else if (baud_cnt_q == 16'd0) begin
      baud_cnt_q <= divisor - 16'd1;
      baud_q     <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_q - 16'd1;
      baud_q     <= 1'b0;
    end
  end

  // RX synchronizer, idle-high reset value.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.UART_RX_I};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Deframer state
  state_e     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       osm_q, osm_d, pen_q, pen_d, stb_q, stb_d;
  logic [1:0] wls_q, wls_d;
  logic       par_err_q, par_err_d;
  logic       stop_err_q, stop_err_d;
  logic       stop_more_q, stop_more_d;
  logic       rx_done_q, rx_done_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [3:0] mid_tick, last_tick;

  // Mid-start lands at MID, every later mid-bit sample OSR ticks after the previous one.
  assign mid_tick  = osm_q ? 4'd5 : 4'd7;
  assign last_tick = osm_q ? 4'd12 : 4'd15;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      osm_q        <= 1'b0;
      pen_q        <= 1'b0;
      stb_q        <= 1'b0;
      wls_q        <= '0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      stop_more_q  <= 1'b0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      osm_q        <= osm_d;
      pen_q        <= pen_d;
      stb_q        <= stb_d;
      wls_q        <= wls_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
      stop_more_q  <= stop_more_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_data_q    <= rx_data_d;
    end
  end

  // Next-state and result logic; the FSM only moves on baud ticks.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    osm_d        = osm_q;
    pen_d        = pen_q;
    stb_d        = stb_q;
    wls_d        = wls_q;
    par_err_d    = par_err_q;
    stop_err_d   = stop_err_q;
    stop_more_d  = stop_more_q;
    rx_done_d    = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    rx_data_d    = rx_data_q;

    if (!bus.BGE) begin
      state_d = StIdle;
    end else if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d    = StStart;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            shift_d    = '0;
            osm_d      = bus.OSM_SEL;
            pen_d      = bus.PEN;
            stb_d      = bus.STB;
            wls_d      = bus.WLS;
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
          end
        end
        StStart: begin
          if (tick_cnt_q == mid_tick) begin
            tick_cnt_d = '0;
            state_d    = rx_s ? StIdle : StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        StData: begin
          if (tick_cnt_q == last_tick) begin
            tick_cnt_d         = '0;
            shift_d[bit_idx_q] = rx_s;
            if (bit_idx_q == (3'd4 + {1'b0, wls_q})) begin
              state_d     = pen_q ? StParity : StStop;
              stop_more_d = stb_q;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        StParity: begin
          if (tick_cnt_q == last_tick) begin
            tick_cnt_d = '0;
            par_err_d  = rx_s ^ (^shift_q);
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        StStop: begin
          if (tick_cnt_q == last_tick) begin
            tick_cnt_d = '0;
            if (stop_more_q) begin
              stop_more_d = 1'b0;
              stop_err_d  = stop_err_q | ~rx_s;
            end else if (stop_err_q || !rx_s) begin
              frame_err_d = 1'b1;
              // A line still held low must be seen high before a new start is hunted.
              state_d     = rx_s ? StIdle : StBreak;
            end else if (par_err_q) begin
              parity_err_d = 1'b1;
              state_d      = StIdle;
            end else begin
              rx_done_d = 1'b1;
              rx_data_d = shift_q;
              state_d   = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        StBreak: begin
          if (rx_s) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.baud_clk   = tick;
  assign bus.rx_done    = rx_done_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames from the test plan plus
// randomized frames, each checked against a frame-level outcome model.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_receiver_if bus ();

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int done_n = 0, perr_n = 0, ferr_n = 0, baud_n = 0, overlap_n = 0;
  logic [7:0] got_q[$];
  logic [7:0] last_good = 8'h00;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_done) begin
        done_n++;
        got_q.push_back(bus.rx_data);
      end
      if (bus.parity_err) perr_n++;
      if (bus.frame_err) ferr_n++;
      if (bus.baud_clk) baud_n++;
      if ((bus.rx_done && (bus.parity_err || bus.frame_err)) ||
          (bus.parity_err && bus.frame_err)) overlap_n++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.UART_RX_I = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; flip inverts the even parity bit, bad drives the first stop bit low.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] wls, input logic pen,
                            input logic flip, input logic stb, input logic bad, input int bt);
    logic [7:0] md;
    md = data & (8'hFF >> (3 - wls));
    hold(1'b0, bt);
    for (int i = 0; i < 5 + int'(wls); i++) hold(md[i], bt);
    if (pen) hold((^md) ^ flip, bt);
    hold(!bad, bt);
    if (stb) hold(1'b1, bt);
    bus.UART_RX_I = 1'b1;
  endtask

  function automatic int bit_time(input logic osm, input int div);
    return div * (osm ? 13 : 16);
  endfunction

  // Frame-level reference: any low stop bit is a framing error, otherwise a parity
  // mismatch rejects, otherwise the masked word is delivered.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [1:0] wls,
                           input logic pen, input logic flip, input logic stb,
                           input logic bad, input int bt);
    int d0, p0, f0;
    logic exp_f, exp_p, exp_d;
    logic [7:0] exp_data;
    exp_f    = bad;
    exp_p    = !bad && pen && flip;
    exp_d    = !exp_f && !exp_p;
    exp_data = exp_d ? (data & (8'hFF >> (3 - wls))) : last_good;
    bus.WLS = wls;
    bus.PEN = pen;
    bus.STB = stb;
    d0 = done_n; p0 = perr_n; f0 = ferr_n;
    send_frame(data, wls, pen, flip, stb, bad, bt);
    hold(1'b1, 2 * bt);
    chk({tag, "_done"}, done_n - d0, exp_d);
    chk({tag, "_perr"}, perr_n - p0, exp_p);
    chk({tag, "_ferr"}, ferr_n - f0, exp_f);
    chk({tag, "_data"}, bus.rx_data, exp_data);
    last_good = exp_data;
  endtask

  task automatic baud_period(output int p);
    int n;
    p = -1;
    n = 0;
    while (!bus.baud_clk && n < 200) begin @(negedge clk); n++; end
    if (bus.baud_clk) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.baud_clk && n < 200);
      if (bus.baud_clk) p = n;
    end
  endtask

  initial begin
    int p, b0, d0, p0, f0, bt, div;
    logic [7:0] rdata;
    logic [1:0] rwls;
    logic rpen, rflip, rstb, rosm;

    bus.DLL = 8'd5; bus.DLH = 8'd0; bus.BGE = 1'b1; bus.OSM_SEL = 1'b0;
    bus.PEN = 1'b0; bus.STB = 1'b0; bus.WLS = 2'b11; bus.UART_RX_I = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_done", bus.rx_done, 1'b0);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_perr", bus.parity_err, 1'b0);
    chk("rst_ferr", bus.frame_err, 1'b0);
    chk("rst_baud", bus.baud_clk, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    baud_period(p);
    chk("baud_div5", p, 5);

    // 5-bit word with parity and two stop bits
    run_frame("t1", 8'h16, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 80);

    // Back-to-back bytes, no idle gap
    bus.WLS = 2'b11; bus.PEN = 1'b0; bus.STB = 1'b0;
    got_q.delete();
    d0 = done_n; p0 = perr_n; f0 = ferr_n;
    send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 80);
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 80);
    hold(1'b1, 160);
    chk("b2b_done", done_n - d0, 2);
    chk("b2b_err", (perr_n - p0) + (ferr_n - f0), 0);
    chk("b2b_first", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'hA5);
    chk("b2b_second", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'h3C);
    last_good = 8'h3C;

    // Short low glitch is a false start
    d0 = done_n; p0 = perr_n; f0 = ferr_n;
    hold(1'b0, 20);
    hold(1'b1, 160);
    chk("glitch_pulses", (done_n - d0) + (perr_n - p0) + (ferr_n - f0), 0);
    baud_period(p);
    chk("glitch_baud", p, 5);
    run_frame("glitch_after", 8'h69, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 80);

    // Parity mismatch keeps previous word
    run_frame("perr", 8'h16, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 80);

    // Low stop bit, then a good frame
    run_frame("ferr", 8'h77, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 80);
    run_frame("after_ferr", 8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 80);

    // 13x oversampling, divisor 3
    bus.OSM_SEL = 1'b1; bus.DLL = 8'd3;
    repeat (10) @(negedge clk);
    baud_period(p);
    chk("baud_div3", p, 3);
    run_frame("osm13", 8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 39);

    // Enable dropped mid-frame
    d0 = done_n; p0 = perr_n; f0 = ferr_n;
    hold(1'b0, 39);
    hold(1'b1, 39);
    hold(1'b0, 20);
    bus.BGE = 1'b0;
    @(negedge clk);
    b0 = baud_n;
    hold(1'b0, 100);
    hold(1'b1, 300);
    chk("bge_baud_cnt", baud_n - b0, 0);
    chk("bge_baud_lvl", bus.baud_clk, 1'b0);
    chk("bge_pulses", (done_n - d0) + (perr_n - p0) + (ferr_n - f0), 0);
    chk("bge_data", bus.rx_data, last_good);
    bus.BGE = 1'b1;
    repeat (20) @(negedge clk);
    run_frame("bge_recover", 8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 39);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      rdata = 8'($urandom);
      rwls  = 2'($urandom_range(0, 3));
      rpen  = 1'($urandom_range(0, 1));
      rflip = rpen & 1'($urandom_range(0, 1));
      rstb  = 1'($urandom_range(0, 1));
      rosm  = 1'($urandom_range(0, 1));
      div   = int'($urandom_range(2, 6));
      bus.OSM_SEL = rosm;
      bus.DLL = 8'(div);
      repeat (12) @(negedge clk);
      bt = bit_time(rosm, div);
      run_frame($sformatf("rnd%0d", k), rdata, rwls, rpen, rflip, rstb, 1'b0, bt);
    end

    // Divisor boundaries
    bus.DLL = 8'd1;
    repeat (10) @(negedge clk);
    b0 = baud_n;
    repeat (10) @(negedge clk);
    chk("baud_div1", baud_n - b0, 10);
    bus.DLL = 8'd0;
    repeat (2) @(negedge clk);
    b0 = baud_n;
    repeat (40) @(negedge clk);
    chk("baud_div0", baud_n - b0, 0);

    chk("exclusive_pulses", overlap_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
